// File: rtl/adder_share_arbiter.sv
// ---------------------------------------------------------------------------
// adder_share_arbiter
//   Shares one external OPERAND_SIZE-bit adder among NUM_REQ requesters.
//   Requests are granted round-robin. Multi-beat (chained) operations keep
//   the grant locked to one requester. The carry out of each beat feeds the
//   next beat. Add and subtract are supported; subtract is A + ~B + 1.
//
// Ports
//   clk, rst                : clock, synchronous active-high reset
//   req_valid/req_ready     : per-requester beat handshake (one-hot ready)
//   req_a/req_b             : packed operands, slice i = requester i
//   req_sub                 : 1 = subtract (taken from the first beat only)
//   req_last                : 1 = final beat of the operation
//   adder_a/b/cin           : drive to the shared adder (b pre-inverted on sub)
//   adder_sum/cout          : combinational result from the shared adder
//   rsp_valid/rsp_ready     : registered response handshake
//   rsp_id/sum/cout/last    : owner, beat result, beat carry, last flag
// ---------------------------------------------------------------------------

// Per-requester slice: arbitration eligibility and AND-OR operand muxing.
module adder_share_arbiter_lane #(
    parameter int W       = 16,
    parameter int ID_W    = 2,
    parameter int LANE_ID = 0
) (
    input  logic            valid,
    input  logic            sub,
    input  logic            last,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic            locked,
    input  logic [ID_W-1:0] lock_id,
    input  logic            sel,
    input  logic            slot_free,
    output logic            eligible,
    output logic            ready,
    output logic [W-1:0]    a_m,
    output logic [W-1:0]    b_m,
    output logic            sub_m,
    output logic            last_m
);
    // While locked, only the owning lane may compete.
    assign eligible = valid && (!locked || (lock_id == ID_W'(LANE_ID)));
    assign ready    = sel && slot_free;
    // Non-selected lanes contribute zero so the top can OR-reduce.
    assign a_m      = sel ? a : '0;
    assign b_m      = sel ? b : '0;
    assign sub_m    = sel && sub;
    assign last_m   = sel && last;
endmodule

module adder_share_arbiter #(
    parameter int OPERAND_SIZE = 16,
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*OPERAND_SIZE-1:0] req_a,
    input  logic [NUM_REQ*OPERAND_SIZE-1:0] req_b,
    input  logic [NUM_REQ-1:0]              req_sub,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [OPERAND_SIZE-1:0]         adder_a,
    output logic [OPERAND_SIZE-1:0]         adder_b,
    output logic                            adder_cin,
    input  logic [OPERAND_SIZE-1:0]         adder_sum,
    input  logic                            adder_cout,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [ID_W-1:0]                 rsp_id,
    output logic [OPERAND_SIZE-1:0]         rsp_sum,
    output logic                            rsp_cout,
    output logic                            rsp_last
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] lock_q, lock_d;
    logic            carry_q, carry_d;
    logic            sub_q, sub_d;

    logic                                   slot_free;
    logic                                   gnt_vld;
    logic [ID_W-1:0]                        gnt_id;
    logic [NUM_REQ-1:0]                     gnt_oh;
    logic [NUM_REQ-1:0]                     eligible;
    logic [NUM_REQ-1:0][OPERAND_SIZE-1:0]   lane_a, lane_b;
    logic [NUM_REQ-1:0]                     lane_sub, lane_last;
    logic [OPERAND_SIZE-1:0]                mux_a, mux_b;
    logic                                   mux_sub, mux_last;
    logic                                   sub_eff;
    logic                                   accept;

    assign slot_free = !rsp_valid || rsp_ready;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        adder_share_arbiter_lane #(
            .W       (OPERAND_SIZE),
            .ID_W    (ID_W),
            .LANE_ID (i)
        ) u_lane (
            .valid     (req_valid[i]),
            .sub       (req_sub[i]),
            .last      (req_last[i]),
            .a         (req_a[i*OPERAND_SIZE +: OPERAND_SIZE]),
            .b         (req_b[i*OPERAND_SIZE +: OPERAND_SIZE]),
            .locked    (state_q == LOCKED),
            .lock_id   (lock_q),
            .sel       (gnt_oh[i]),
            .slot_free (slot_free),
            .eligible  (eligible[i]),
            .ready     (req_ready[i]),
            .a_m       (lane_a[i]),
            .b_m       (lane_b[i]),
            .sub_m     (lane_sub[i]),
            .last_m    (lane_last[i])
        );
    end

    // Round-robin search from ptr_q with wrap. Walking the offsets from the
    // far end down lets the nearest eligible requester win last. In LOCKED
    // only the owner is eligible, so the same search yields the lock.
    always_comb begin
        logic [ID_W:0] idx_w;
        idx_w   = '0;
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx_w = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (idx_w >= (ID_W+1)'(NUM_REQ))
                idx_w = idx_w - (ID_W+1)'(NUM_REQ);
            if (eligible[idx_w[ID_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_id  = idx_w[ID_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        if (gnt_vld)
            gnt_oh[gnt_id] = 1'b1;
    end

    always_comb begin
        mux_a    = '0;
        mux_b    = '0;
        mux_sub  = 1'b0;
        mux_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            mux_a    = mux_a | lane_a[i];
            mux_b    = mux_b | lane_b[i];
            mux_sub  = mux_sub | lane_sub[i];
            mux_last = mux_last | lane_last[i];
        end
    end

    // Later beats follow the opcode latched on the first beat.
    assign sub_eff   = (state_q == LOCKED) ? sub_q : mux_sub;
    assign adder_a   = mux_a;
    assign adder_b   = (gnt_vld && sub_eff) ? ~mux_b : mux_b;
    assign adder_cin = gnt_vld && ((state_q == LOCKED) ? carry_q : mux_sub);

    assign accept = gnt_vld && slot_free;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        if (accept) begin
            if (state_q == IDLE)
                sub_d = mux_sub;
            if (mux_last) begin
                state_d = IDLE;
                carry_d = 1'b0;
                ptr_d   = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            end else begin
                state_d = LOCKED;
                lock_d  = gnt_id;
                carry_d = adder_cout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            lock_q  <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
        end
    end

    // Response register: a new beat may replace an outgoing one in the same
    // cycle, giving one beat per cycle sustained.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_last  <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_id    <= gnt_id;
            rsp_sum   <= adder_sum;
            rsp_cout  <= adder_cout;
            rsp_last  <= mux_last;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
module tb_adder_share_arbiter;
    localparam int W = 16;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid, req_ready, req_sub, req_last;
    logic [N*W-1:0]   req_a, req_b;
    logic [W-1:0]     adder_a, adder_b, adder_sum;
    logic             adder_cin, adder_cout;
    logic             rsp_valid, rsp_ready;
    logic [1:0]       rsp_id;
    logic [W-1:0]     rsp_sum;
    logic             rsp_cout, rsp_last;

    always #5 clk = ~clk;

    // External adder model.
    assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {16'b0, adder_cin};

    adder_share_arbiter #(.OPERAND_SIZE(W), .NUM_REQ(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .req_last(req_last),
        .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
        .adder_sum(adder_sum), .adder_cout(adder_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_last(rsp_last)
    );

    typedef struct {
        logic [1:0]   id;
        logic [W-1:0] sum;
        logic         cout;
        logic         last;
    } rsp_t;

    rsp_t        sb[$];
    int          tests = 0;
    int          fails = 0;

    // Per-requester operation state (wide operands, beat counter).
    bit          has_op[N];
    bit          en[N];
    logic [63:0] op_a[N], op_b[N];
    bit          op_sub[N];
    int          op_nb[N], op_bt[N];

    // Arbiter reference state.
    bit          m_locked;
    int          m_owner, m_ptr;
    bit          m_rsp_valid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Beat k result taken from the wide sum of the low (k+1) beats.
    function automatic void beat_res(input logic [63:0] a, input logic [63:0] b, input bit sub,
                                     input int k, output logic [W-1:0] s, output logic c);
        logic [79:0] mask, aa, bb, p;
        mask = (80'd1 << ((k + 1) * 16)) - 80'd1;
        aa   = {16'b0, a} & mask;
        bb   = {16'b0, (sub ? ~b : b)} & mask;
        p    = aa + bb + (sub ? 80'd1 : 80'd0);
        s    = p[k*16 +: 16];
        c    = p[(k + 1) * 16];
    endfunction

    task automatic new_op(input int i, input logic [63:0] a, input logic [63:0] b,
                          input bit sub, input int nb);
        has_op[i] = 1'b1; op_a[i] = a; op_b[i] = b; op_sub[i] = sub;
        op_nb[i] = nb; op_bt[i] = 0;
    endtask

    task automatic rand_op(input int i, input int max_nb);
        new_op(i, {$urandom, $urandom}, {$urandom, $urandom}, bit'($urandom % 2),
               int'($urandom_range(1, max_nb)));
    endtask

    // One clock: drive at negedge, check combinational outputs, predict the
    // accepted beat and push its expected response.
    task automatic cycle();
        int           g;
        bit           gv, sf, lst;
        logic [N-1:0] exp_rdy;
        logic [W-1:0] s, ea, eb;
        logic         c, cin_e;
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = has_op[i] && en[i];
            req_a[i*W +: W]    = op_a[i][op_bt[i]*16 +: 16];
            req_b[i*W +: W]    = op_b[i][op_bt[i]*16 +: 16];
            req_sub[i]         = op_sub[i];
            req_last[i]        = (op_bt[i] == op_nb[i] - 1);
        end
        #1;
        gv = 1'b0; g = 0;
        if (m_locked) begin
            gv = req_valid[m_owner]; g = m_owner;
        end else begin
            for (int k = 0; k < N; k++)
                if (!gv && req_valid[(m_ptr + k) % N]) begin gv = 1'b1; g = (m_ptr + k) % N; end
        end
        sf      = !m_rsp_valid || rsp_ready;
        exp_rdy = (gv && sf) ? (4'b0001 << g) : 4'b0000;
        chk("rsp_valid", rsp_valid, m_rsp_valid);
        chk("req_ready", req_ready, exp_rdy);
        if (gv) begin
            ea = op_a[g][op_bt[g]*16 +: 16];
            eb = op_b[g][op_bt[g]*16 +: 16];
            if (op_sub[g]) eb = ~eb;
            if (op_bt[g] == 0) cin_e = op_sub[g];
            else beat_res(op_a[g], op_b[g], op_sub[g], op_bt[g] - 1, s, cin_e);
            chk("adder_a", adder_a, ea);
            chk("adder_b", adder_b, eb);
            chk("adder_cin", adder_cin, cin_e);
        end else begin
            chk("adder_idle", {adder_a, adder_b, adder_cin}, 64'd0);
        end
        if (gv && sf) begin
            rsp_t r;
            lst = (op_bt[g] == op_nb[g] - 1);
            beat_res(op_a[g], op_b[g], op_sub[g], op_bt[g], s, c);
            r.id = g[1:0]; r.sum = s; r.cout = c; r.last = lst;
            sb.push_back(r);
            op_bt[g]++;
            if (lst) begin
                has_op[g] = 1'b0; m_locked = 1'b0; m_ptr = (g + 1) % N;
            end else begin
                m_locked = 1'b1; m_owner = g;
            end
            m_rsp_valid = 1'b1;
        end else if (rsp_ready) begin
            m_rsp_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_rsp_valid = 1'b0;
        for (int i = 0; i < N; i++) begin has_op[i] = 1'b0; en[i] = 1'b0; end
    endtask

    task automatic all_off();
        for (int i = 0; i < N; i++) begin has_op[i] = 1'b0; en[i] = 1'b0; end
    endtask

    // Monitor: compare the presented response against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && rsp_valid) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rsp_unexpected: got id %0d sum %0h, expected no response", rsp_id, rsp_sum);
                end else begin
                    chk("rsp_id", rsp_id, sb[0].id);
                    chk("rsp_sum", rsp_sum, sb[0].sum);
                    chk("rsp_cout", rsp_cout, sb[0].cout);
                    chk("rsp_last", rsp_last, sb[0].last);
                    if (rsp_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1; rsp_ready = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0; req_sub = '0; req_last = '0;
        for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; op_nb[i] = 1; op_bt[i] = 0; end
        @(negedge clk);
        do_reset();
        chk("reset_rsp", {rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last}, 64'd0);

        // Single add on r0.
        new_op(0, 64'h1234, 64'h4321, 1'b0, 1); en[0] = 1'b1;
        cycle();
        chk("add_sum", rsp_sum, 64'h5555);
        chk("add_id_last", {rsp_id, rsp_cout, rsp_last}, {2'd0, 1'b0, 1'b1});
        all_off(); cycle();

        // Subtract on r2: 5 - 7.
        new_op(2, 64'h0005, 64'h0007, 1'b1, 1); en[2] = 1'b1;
        cycle();
        chk("sub_sum", rsp_sum, 64'hFFFE);
        chk("sub_cout", rsp_cout, 64'd0);
        all_off(); cycle();

        // Two-beat add on r1: 0x0001FFFF + 1.
        new_op(1, 64'h0001_FFFF, 64'h1, 1'b0, 2); en[1] = 1'b1;
        cycle();
        chk("chain_b0", {rsp_sum, rsp_cout}, {16'h0000, 1'b1});
        cycle();
        chk("chain_b1", {rsp_sum, rsp_cout, rsp_last}, {16'h0002, 1'b0, 1'b1});
        all_off(); cycle();

        // Round robin from pointer 0, all requesters continuously valid.
        do_reset();
        for (int i = 0; i < N; i++) begin rand_op(i, 1); en[i] = 1'b1; end
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("rr_id", rsp_id, 64'(k % 4));
            for (int i = 0; i < N; i++) if (!has_op[i]) rand_op(i, 1);
        end
        all_off(); cycle();

        // Lock with a gap: r1 three beats, r0 valid throughout.
        new_op(1, 64'h0000_FFFF_FFFF, 64'h1, 1'b0, 3); en[1] = 1'b1;
        cycle();
        new_op(0, 64'h7, 64'h9, 1'b0, 1); en[0] = 1'b1;
        en[1] = 1'b0; cycle(); cycle();
        en[1] = 1'b1; cycle();
        chk("gap_carry", {rsp_sum, rsp_cout}, {16'h0000, 1'b1});
        cycle();
        chk("gap_last_id", {rsp_id, rsp_last}, {2'd1, 1'b1});
        cycle();
        chk("gap_r0_id", rsp_id, 64'd0);
        all_off(); cycle();

        // Backpressure with r3 waiting.
        rsp_ready = 1'b0;
        new_op(0, 64'h11, 64'h22, 1'b0, 1); en[0] = 1'b1;
        cycle();
        new_op(3, 64'h100, 64'h200, 1'b1, 1); en[3] = 1'b1;
        repeat (3) cycle();
        chk("bp_ready", req_ready, 64'd0);
        rsp_ready = 1'b1;
        cycle();
        chk("bp_id", rsp_id, 64'd3);
        all_off(); cycle();

        // Reset in the middle of a chained operation on r2.
        new_op(2, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 3); en[2] = 1'b1;
        cycle();
        do_reset();
        chk("midrst_valid", rsp_valid, 64'd0);
        new_op(0, 64'h5, 64'h6, 1'b0, 1); en[0] = 1'b1;
        new_op(2, 64'h7, 64'h8, 1'b0, 1); en[2] = 1'b1;
        cycle();
        chk("midrst_id", rsp_id, 64'd0);
        all_off(); cycle();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!has_op[i] && ($urandom % 4 == 0)) rand_op(i, 4);
                en[i] = ($urandom % 4 != 0);
            end
            rsp_ready = ($urandom % 4 != 0);
            cycle();
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) en[i] = 1'b0;
        repeat (3) cycle();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
